// File: rtl/controle_musicas_seq_pkg.sv
// Shared types and constants for the song sequencer: FSM encoding, memory
// geometry and the end-of-song marker value.
package controle_musicas_seq_pkg;

    typedef enum logic [3:0] {
        OCIOSO,
        LE_ESPERA,
        AVALIA,
        TOCA,
        PROXIMA,
        GRAVA,
        ESCREVE,
        TERMINA,
        FIM
    } estado_t;

    localparam logic [4:0] ADDR_ULTIMA         = 5'd31;
    localparam logic [4:0] ADDR_PENULTIMA      = 5'd30;
    localparam int         TEMPO_ZERO_UNIDADES = 16;
    localparam logic [3:0] NOTA_FIM            = 4'd0;
    localparam logic [3:0] TEMPO_FIM           = 4'd0;

    // A stored tempo of 0 on a real note means the longest duration.
    function automatic logic [4:0] unidades_tempo(input logic [3:0] tempo);
        return (tempo == 4'd0) ? 5'(TEMPO_ZERO_UNIDADES) : {1'b0, tempo};
    endfunction

endpackage

// File: rtl/controle_musicas_seq_contador.sv
// Loadable down-counter that stops at zero; zero_o flags an exhausted count.
module contador_duracao #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         limpar_i,
    input  logic         carregar_i,
    input  logic [W-1:0] valor_i,
    input  logic         decrementar_i,
    output logic         zero_o
);

    logic [W-1:0] contagem_q;

    always_ff @(posedge clk) begin
        if (reset || limpar_i) begin
            contagem_q <= '0;
        end else if (carregar_i) begin
            contagem_q <= valor_i;
        end else if (decrementar_i && (contagem_q != '0)) begin
            contagem_q <= contagem_q - W'(1);
        end
    end

    assign zero_o = (contagem_q == '0);

endmodule

// File: rtl/controle_musicas_seq.sv
// Song sequencer: plays a song from the note/tempo bank word by word, or
// records user notes into it and closes the song with an end marker.
module controle_musicas_seq
    import controle_musicas_seq_pkg::*;
#(
    parameter int TICKS_POR_TEMPO = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       gravar_inicio,
    input  logic       gravar_nota,
    input  logic       gravar_fim,
    input  logic       abortar,
    input  logic [3:0] musica_in,
    input  logic [3:0] nota_in,
    input  logic [3:0] tempo_in,
    input  logic [3:0] mem_nota,
    input  logic [3:0] mem_tempo,
    input  logic       mem_fim_musica,
    output logic [4:0] mem_addr,
    output logic [3:0] mem_musica,
    output logic       mem_we,
    output logic [3:0] mem_data_nota,
    output logic [3:0] mem_data_tempo,
    output logic [3:0] nota_tocando,
    output logic       tocando,
    output logic       ocupado,
    output logic       cheio,
    output logic       pronto
);

    localparam int              CW      = $clog2(TICKS_POR_TEMPO) + 5;
    localparam logic [CW-1:0]   TICKS_W = CW'(TICKS_POR_TEMPO);

    estado_t       estado_q, estado_d;
    logic [4:0]    addr_q, addr_d;
    logic [3:0]    musica_q, musica_d;
    logic          cheio_q, cheio_d;
    logic [3:0]    nota_q, nota_d;
    logic [3:0]    data_nota_q, data_nota_d;
    logic [3:0]    data_tempo_q, data_tempo_d;
    logic          cont_limpar, cont_carregar, cont_zero;
    logic [CW-1:0] cont_carga;

    // Counter holds the last TOCA cycle at zero, so load with duration-1.
    assign cont_carga = CW'(unidades_tempo(mem_tempo)) * TICKS_W - CW'(1);

    contador_duracao #(.W(CW)) u_contador (
        .clk           (clk),
        .reset         (reset),
        .limpar_i      (cont_limpar),
        .carregar_i    (cont_carregar),
        .valor_i       (cont_carga),
        .decrementar_i (estado_q == TOCA),
        .zero_o        (cont_zero)
    );

    always_comb begin
        estado_d      = estado_q;
        addr_d        = addr_q;
        musica_d      = musica_q;
        cheio_d       = cheio_q;
        nota_d        = nota_q;
        data_nota_d   = data_nota_q;
        data_tempo_d  = data_tempo_q;
        cont_limpar   = 1'b0;
        cont_carregar = 1'b0;
        if (abortar) begin
            estado_d     = OCIOSO;
            addr_d       = '0;
            musica_d     = '0;
            cheio_d      = 1'b0;
            nota_d       = '0;
            data_nota_d  = '0;
            data_tempo_d = '0;
            cont_limpar  = 1'b1;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        musica_d = musica_in;
                        addr_d   = '0;
                        estado_d = LE_ESPERA;
                    end else if (gravar_inicio) begin
                        musica_d = musica_in;
                        addr_d   = '0;
                        cheio_d  = 1'b0;
                        estado_d = GRAVA;
                    end
                end
                LE_ESPERA: estado_d = AVALIA;
                AVALIA: begin
                    if (mem_fim_musica) begin
                        estado_d = FIM;
                    end else begin
                        nota_d        = mem_nota;
                        cont_carregar = 1'b1;
                        estado_d      = TOCA;
                    end
                end
                TOCA: begin
                    if (cont_zero) begin
                        estado_d = (addr_q == ADDR_ULTIMA) ? FIM : PROXIMA;
                    end
                end
                PROXIMA: begin
                    addr_d   = addr_q + 5'd1;
                    estado_d = LE_ESPERA;
                end
                GRAVA: begin
                    if (gravar_nota && !cheio_q) begin
                        data_nota_d  = nota_in;
                        data_tempo_d = tempo_in;
                        estado_d     = ESCREVE;
                    end else if (gravar_fim) begin
                        data_nota_d  = NOTA_FIM;
                        data_tempo_d = TEMPO_FIM;
                        estado_d     = TERMINA;
                    end
                end
                ESCREVE: begin
                    // Word 31 is reserved for the terminator of a full song.
                    if (addr_q == ADDR_PENULTIMA) begin
                        cheio_d = 1'b1;
                        addr_d  = ADDR_ULTIMA;
                    end else begin
                        addr_d = addr_q + 5'd1;
                    end
                    estado_d = GRAVA;
                end
                TERMINA: estado_d = FIM;
                FIM:     estado_d = OCIOSO;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            addr_q       <= '0;
            musica_q     <= '0;
            cheio_q      <= 1'b0;
            nota_q       <= '0;
            data_nota_q  <= '0;
            data_tempo_q <= '0;
        end else begin
            estado_q     <= estado_d;
            addr_q       <= addr_d;
            musica_q     <= musica_d;
            cheio_q      <= cheio_d;
            nota_q       <= nota_d;
            data_nota_q  <= data_nota_d;
            data_tempo_q <= data_tempo_d;
        end
    end

    assign mem_addr       = addr_q;
    assign mem_musica     = musica_q;
    assign mem_we         = (estado_q == ESCREVE) || (estado_q == TERMINA);
    assign mem_data_nota  = data_nota_q;
    assign mem_data_tempo = data_tempo_q;
    assign tocando        = (estado_q == TOCA);
    assign nota_tocando   = (estado_q == TOCA) ? nota_q : 4'd0;
    assign ocupado        = (estado_q != OCIOSO);
    assign cheio          = cheio_q;
    assign pronto         = (estado_q == FIM);

endmodule
